// File: rtl/vga_565_capture.sv
// RGB565 video capture front end: two-stage pixel/sync pipeline with 565->888
// expansion, pixel/line counters and a sync-timing lock detector.
module vga_565_capture #(
    parameter int X_W    = 12,
    parameter int Y_W    = 11,
    parameter int HS_POL = 1,
    parameter int VS_POL = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [4:0]     r_i,
    input  logic [5:0]     g_i,
    input  logic [4:0]     b_i,
    input  logic           hs_i,
    input  logic           vs_i,
    output logic [7:0]     r_o,
    output logic [7:0]     g_o,
    output logic [7:0]     b_o,
    output logic           hs_o,
    output logic           vs_o,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic [X_W-1:0] h_total_o,
    output logic [Y_W-1:0] v_total_o,
    output logic           locked,
    output logic [1:0]     dbg_state
);

    localparam logic           HS_ACT = (HS_POL != 0);
    localparam logic           VS_ACT = (VS_POL != 0);
    localparam logic [X_W-1:0] X_MAX  = '1;
    localparam logic [X_W-1:0] X_ONE  = 1;
    localparam logic [Y_W-1:0] Y_ONE  = 1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        VERIFY  = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     r_s1, b_s1;
    logic [5:0]     g_s1;
    logic           hs_s1, vs_s1;
    logic           hs_prev, vs_prev;
    logic           hs_edge, vs_edge;
    logic [X_W-1:0] line_len, h_len_q, cur_h, h_ref;
    logic [Y_W-1:0] hs_cnt, frame_len, v_ref;
    logic           mismatch;
    logic           ref_load;

    // Previous sync state resets to inactive so an active level seen right
    // after reset is treated as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= '0;
            g_s1    <= '0;
            b_s1    <= '0;
            hs_s1   <= 1'b0;
            vs_s1   <= 1'b0;
            hs_prev <= ~HS_ACT;
            vs_prev <= ~VS_ACT;
            r_o     <= '0;
            g_o     <= '0;
            b_o     <= '0;
            hs_o    <= 1'b0;
            vs_o    <= 1'b0;
        end else begin
            r_s1    <= r_i;
            g_s1    <= g_i;
            b_s1    <= b_i;
            hs_s1   <= hs_i;
            vs_s1   <= vs_i;
            hs_prev <= hs_s1;
            vs_prev <= vs_s1;
            r_o     <= {r_s1, r_s1[4:2]};
            g_o     <= {g_s1, g_s1[5:4]};
            b_o     <= {b_s1, b_s1[4:2]};
            hs_o    <= hs_s1;
            vs_o    <= vs_s1;
        end
    end

    assign hs_edge   = (hs_s1 == HS_ACT) && (hs_prev != HS_ACT);
    assign vs_edge   = (vs_s1 == VS_ACT) && (vs_prev != VS_ACT);
    assign line_len  = x_o + X_ONE;
    assign frame_len = hs_cnt + {{(Y_W-1){1'b0}}, hs_edge};
    // A vs edge without a coincident hs edge judges the last completed line.
    assign cur_h     = hs_edge ? line_len : h_len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_o      <= '0;
            y_o      <= '0;
            hs_cnt   <= '0;
            h_len_q  <= '0;
            mismatch <= 1'b0;
        end else begin
            if (hs_edge)
                x_o <= '0;
            else if (x_o != X_MAX)
                x_o <= x_o + X_ONE;

            if (vs_edge)
                y_o <= '0;
            else if (hs_edge)
                y_o <= y_o + Y_ONE;

            if (vs_edge)
                hs_cnt <= '0;
            else if (hs_edge)
                hs_cnt <= hs_cnt + Y_ONE;

            if (hs_edge)
                h_len_q <= line_len;

            if (vs_edge)
                mismatch <= 1'b0;
            else if (hs_edge && (line_len != h_len_q))
                mismatch <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        ref_load = 1'b0;
        case (state_q)
            SEARCH: begin
                if (vs_edge)
                    state_d = MEASURE;
            end
            MEASURE: begin
                if (vs_edge) begin
                    ref_load = 1'b1;
                    if (!mismatch)
                        state_d = VERIFY;
                end
            end
            VERIFY: begin
                if (vs_edge) begin
                    if (!mismatch && (cur_h == h_ref) && (frame_len == v_ref)) begin
                        state_d = LOCKED;
                    end else begin
                        ref_load = 1'b1;
                        state_d  = MEASURE;
                    end
                end
            end
            LOCKED: begin
                if ((hs_edge && (line_len != h_ref)) || (vs_edge && (frame_len != v_ref)))
                    state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
        // A saturated pixel counter means sync has been lost.
        if (x_o == X_MAX) begin
            state_d  = SEARCH;
            ref_load = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SEARCH;
            h_ref     <= '0;
            v_ref     <= '0;
            locked    <= 1'b0;
            h_total_o <= '0;
            v_total_o <= '0;
        end else begin
            state_q <= state_d;
            if (ref_load) begin
                h_ref <= cur_h;
                v_ref <= frame_len;
            end
            locked    <= (state_d == LOCKED);
            h_total_o <= (state_d == LOCKED) ? h_ref : '0;
            v_total_o <= (state_d == LOCKED) ? v_ref : '0;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_vga_565_capture.sv
// Directed bench for vga_565_capture: expansion, lock/perturb/timeout and
// asynchronous reset behaviour with hand-computed expectations.
module tb_vga_565_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  r_i, b_i;
    logic [5:0]  g_i;
    logic        hs_i, vs_i;
    logic [7:0]  r_o, g_o, b_o;
    logic        hs_o, vs_o;
    logic [11:0] x_o, h_total_o;
    logic [10:0] y_o, v_total_o;
    logic        locked;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    vga_565_capture dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r_i       (r_i),
        .g_i       (g_i),
        .b_i       (b_i),
        .hs_i      (hs_i),
        .vs_i      (vs_i),
        .r_o       (r_o),
        .g_o       (g_o),
        .b_o       (b_o),
        .hs_o      (hs_o),
        .vs_o      (vs_o),
        .x_o       (x_o),
        .y_o       (y_o),
        .h_total_o (h_total_o),
        .v_total_o (v_total_o),
        .locked    (locked),
        .dbg_state (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one clock of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic hs, input logic vs, input logic [4:0] r,
                        input logic [5:0] g, input logic [4:0] b);
        hs_i = hs;
        vs_i = vs;
        r_i  = r;
        g_i  = g;
        b_i  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic sync_step(input logic hs, input logic vs);
        step(hs, vs, 5'h1f, 6'h00, 5'h10);
    endtask

    task automatic line(input int len, input logic vs);
        sync_step(1'b1, vs);
        for (int i = 1; i < len; i++) sync_step(1'b0, 1'b0);
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) line(10, 1'b0);
    endtask

    task automatic frame_vs();
        line(10, 1'b1);
        lines(3);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rgb"},    32'({r_o, g_o, b_o}), 32'd0);
        chk({tag, "_sync"},   32'({hs_o, vs_o}), 32'd0);
        chk({tag, "_x"},      32'(x_o), 32'd0);
        chk({tag, "_y"},      32'(y_o), 32'd0);
        chk({tag, "_htot"},   32'(h_total_o), 32'd0);
        chk({tag, "_vtot"},   32'(v_total_o), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_state"},  32'(dbg_state), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        hs_i  = 1'b0;
        vs_i  = 1'b0;
        r_i   = '0;
        g_i   = '0;
        b_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        #2 rst_n = 1'b1;

        // Expansion with constant sync: x counts one per clock from reset.
        exp_q.push_back(24'hffffff);
        exp_q.push_back(24'h848284);
        exp_q.push_back(24'h000000);
        step(1'b0, 1'b0, 5'h1f, 6'h3f, 5'h1f);
        step(1'b0, 1'b0, 5'h10, 6'h20, 5'h10);
        chk("exp_max", 32'({r_o, g_o, b_o}), 32'(exp_q.pop_front()));
        chk("x_free2", 32'(x_o), 32'd2);
        step(1'b0, 1'b0, 5'h00, 6'h00, 5'h00);
        chk("exp_msb", 32'({r_o, g_o, b_o}), 32'(exp_q.pop_front()));
        chk("x_free3", 32'(x_o), 32'd3);
        step(1'b0, 1'b0, 5'h00, 6'h00, 5'h00);
        chk("exp_zero", 32'({r_o, g_o, b_o}), 32'(exp_q.pop_front()));
        chk("x_free4", 32'(x_o), 32'd4);
        chk("y_free", 32'(y_o), 32'd0);
        chk("hs_quiet", 32'(hs_o), 32'd0);

        // Lock: 10-clock lines, vs with every 4th hs edge.
        lines(2);
        frame_vs();
        frame_vs();
        chk("lock_not_yet", 32'(locked), 32'd0);
        sync_step(1'b1, 1'b1);
        chk("lock_edge_cycle", 32'(locked), 32'd0);
        sync_step(1'b0, 1'b0);
        chk("lock_rise", 32'(locked), 32'd1);
        chk("coinc_x", 32'(x_o), 32'd0);
        chk("coinc_y", 32'(y_o), 32'd0);
        chk("lock_htot", 32'(h_total_o), 32'd10);
        chk("lock_vtot", 32'(v_total_o), 32'd4);
        chk("sync_delay", 32'({hs_o, vs_o}), 32'd3);
        chk("lock_state", 32'(dbg_state), 32'd3);
        for (int i = 1; i <= 8; i++) begin
            sync_step(1'b0, 1'b0);
            chk("x_cycle", 32'(x_o), 32'(i));
        end
        line(10, 1'b0);
        chk("x_last", 32'(x_o), 32'd8);
        chk("y_line1", 32'(y_o), 32'd1);
        line(10, 1'b0);
        chk("y_line2", 32'(y_o), 32'd2);
        line(10, 1'b0);
        chk("y_line3", 32'(y_o), 32'd3);
        chk("lock_hold", 32'(locked), 32'd1);

        // Perturb: one 11-clock line mid-frame.
        line(10, 1'b1);
        chk("y_wrap", 32'(y_o), 32'd0);
        line(10, 1'b0);
        line(11, 1'b0);
        chk("long_x", 32'(x_o), 32'd9);
        chk("long_locked", 32'(locked), 32'd1);
        sync_step(1'b1, 1'b0);
        chk("perturb_edge", 32'(locked), 32'd1);
        sync_step(1'b0, 1'b0);
        chk("perturb_drop", 32'(locked), 32'd0);
        chk("perturb_htot", 32'(h_total_o), 32'd0);
        chk("perturb_vtot", 32'(v_total_o), 32'd0);
        chk("perturb_state", 32'(dbg_state), 32'd0);
        for (int i = 0; i < 8; i++) sync_step(1'b0, 1'b0);
        frame_vs();
        frame_vs();
        sync_step(1'b1, 1'b1);
        chk("relock_pre", 32'(locked), 32'd0);
        sync_step(1'b0, 1'b0);
        chk("relock", 32'(locked), 32'd1);
        chk("relock_htot", 32'(h_total_o), 32'd10);
        for (int i = 0; i < 8; i++) sync_step(1'b0, 1'b0);
        lines(3);

        // Timeout: hs stops while locked.
        repeat (4086) sync_step(1'b0, 1'b0);
        chk("to_x_4094", 32'(x_o), 32'd4094);
        chk("to_still_locked", 32'(locked), 32'd1);
        sync_step(1'b0, 1'b0);
        chk("to_x_sat", 32'(x_o), 32'd4095);
        chk("to_sat_locked", 32'(locked), 32'd1);
        sync_step(1'b0, 1'b0);
        chk("to_x_hold", 32'(x_o), 32'd4095);
        chk("to_drop", 32'(locked), 32'd0);
        chk("to_state", 32'(dbg_state), 32'd0);

        // Relock, then asynchronous reset mid-frame.
        lines(2);
        frame_vs();
        frame_vs();
        sync_step(1'b1, 1'b1);
        sync_step(1'b0, 1'b0);
        chk("relock2", 32'(locked), 32'd1);
        repeat (3) sync_step(1'b0, 1'b0);
        chk("pre_rst_rgb", 32'({r_o, g_o, b_o}), 32'hff0084);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        #1 rst_n = 1'b1;
        repeat (5) sync_step(1'b0, 1'b0);
        chk("post_rst_unlocked", 32'(locked), 32'd0);
        lines(3);
        frame_vs();
        frame_vs();
        chk("post_rst_wait", 32'(locked), 32'd0);
        line(10, 1'b1);
        chk("post_rst_relock", 32'(locked), 32'd1);
        chk("post_rst_htot", 32'(h_total_o), 32'd10);
        chk("post_rst_vtot", 32'(v_total_o), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
